// File: rtl/wb_copy16_pkg.sv
// Shared types and constants for the wb_copy16 halfword block-copy initiator.
// Holds the FSM state encoding, byte-select pattern and address step.
package wb_copy16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RD_GAP = 3'd2,
        ST_WR     = 3'd3,
        ST_WR_GAP = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [1:0]  SEL_ALL  = 2'b11;
    localparam logic [31:0] ADR_STEP = 32'd2;

    // Halfword transfers only, so the byte-lane bit of any address is dropped.
    function automatic logic [31:0] halfword_align(input logic [31:0] adr);
        return {adr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/wb_copy16_if.sv
// Wishbone classic 16-bit bus bundle between the copy engine and its responder.
// master = copy engine side, slave = memory/responder side.
interface wb_copy16_if;

    logic [31:0] adr;
    logic [15:0] dat_w;
    logic [15:0] dat_r;
    logic        we;
    logic [1:0]  sel;
    logic        stb;
    logic        cyc;
    logic        tga;
    logic        ack;

    modport master (
        output adr, dat_w, we, sel, stb, cyc, tga,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, we, sel, stb, cyc, tga,
        output dat_r, ack
    );

endinterface

// File: rtl/wb_copy16.sv
// Wishbone classic initiator copying a block of halfwords from a source region to a
// destination region, one read then one write per halfword, with a strobe timeout.
module wb_copy16
    import wb_copy16_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int LEN_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       src_adr_i,
    input  logic [31:0]       dst_adr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    wb_copy16_if.master       wb
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [31:0]       src_q, src_d;
    logic [31:0]       dst_q, dst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [15:0]       data_q, data_d;
    logic [31:0]       adr_q, adr_d;
    logic [15:0]       dat_q, dat_d;
    logic              we_q, we_d;
    logic [1:0]        sel_q, sel_d;
    logic              stb_q, stb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ack_ok;

    // An ack only counts while our strobe is up; a lingering ack lands in a gap state.
    assign ack_ok = wb.ack && stb_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 2'b00;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        stb_d   = stb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    src_d  = halfword_align(src_adr_i);
                    dst_d  = halfword_align(dst_adr_i);
                    cnt_d  = len_i;
                    busy_d = 1'b1;
                    if (len_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        adr_d   = halfword_align(src_adr_i);
                        tmo_d   = '0;
                    end
                end
            end
            ST_RD: begin
                if (ack_ok) begin
                    data_d  = wb.dat_r;
                    stb_d   = 1'b0;
                    src_d   = src_q + ADR_STEP;
                    state_d = ST_RD_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    stb_d   = 1'b0;
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_RD_GAP: begin
                state_d = ST_WR;
                stb_d   = 1'b1;
                we_d    = 1'b1;
                adr_d   = dst_q;
                dat_d   = data_q;
                tmo_d   = '0;
            end
            ST_WR: begin
                if (ack_ok) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    dst_d   = dst_q + ADR_STEP;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = ST_WR_GAP;
                end else if (tmo_q == TMO_LAST) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_ERR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_WR_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = src_q;
                    tmo_d   = '0;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = 1'b0;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        sel_d = stb_d ? SEL_ALL : 2'b00;
    end

    assign wb.adr   = adr_q;
    assign wb.dat_w = dat_q;
    assign wb.we    = we_q;
    assign wb.sel   = sel_q;
    assign wb.stb   = stb_q;
    assign wb.cyc   = stb_q;
    assign wb.tga   = 1'b0;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_wb_copy16.sv
// Self-checking bench for wb_copy16: ROM/RAM responder with selectable ack behaviour,
// transfer log, and a halfword-copy reference model built from the ROM contents.
module tb_wb_copy16;

    localparam int TMO = 8;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [15:0] dat;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_adr;
    logic [31:0] dst_adr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        err;

    wb_copy16_if wb();

    wb_copy16 #(.TIMEOUT(TMO), .LEN_W(16)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .src_adr_i (src_adr),
        .dst_adr_i (dst_adr),
        .len_i     (len),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .wb        (wb)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:65535];
    logic [7:0] ram [0:65535];
    xfer_t      log_q[$];
    xfer_t      exp_q[$];
    int         ack_mode;
    int         stb_cycles = 0;
    int         cyc_cycles = 0;
    int         bus_bad = 0;
    int         vectors;
    int         miscompares;

    // Responder: mode 0 one-shot registered ack, mode 1 ack lingers a cycle, mode 2 never acks.
    always @(posedge clk) begin
        if (!rst) begin
            if (wb.stb) stb_cycles++;
            if (wb.cyc) cyc_cycles++;
            if (wb.cyc !== wb.stb || wb.tga !== 1'b0 || wb.sel !== (wb.stb ? 2'b11 : 2'b00))
                bus_bad++;
            if (wb.stb && wb.ack)
                log_q.push_back('{wb.adr, wb.we, wb.we ? wb.dat_w : wb.dat_r});
        end
        if (rst) begin
            wb.ack <= 1'b0;
        end else begin
            case (ack_mode)
                0:       wb.ack <= wb.stb && wb.cyc && !wb.ack;
                1:       wb.ack <= wb.stb && wb.cyc;
                default: wb.ack <= 1'b0;
            endcase
            if (wb.stb && wb.cyc) begin
                wb.dat_r <= {rom[wb.adr[15:0]], rom[16'(wb.adr + 32'd1)]};
                if (wb.we) begin
                    ram[wb.adr[15:0]]         = wb.dat_w[15:8];
                    ram[16'(wb.adr + 32'd1)]  = wb.dat_w[7:0];
                end
            end
        end
    end

    // Reference model: halfword i of the copy is the ROM pair at (src&~1)+2i, written to (dst&~1)+2i.
    task automatic build_expect(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa;
        logic [31:0] da;
        logic [15:0] hw;
        exp_q.delete();
        sa = s & 32'hFFFF_FFFE;
        da = d & 32'hFFFF_FFFE;
        for (int i = 0; i < n; i++) begin
            hw = {rom[16'(sa)], rom[16'(sa + 32'd1)]};
            exp_q.push_back('{sa, 1'b0, hw});
            exp_q.push_back('{da, 1'b1, hw});
            sa = sa + 32'd2;
            da = da + 32'd2;
        end
    endtask

    task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n, input int poke_at,
                           output int done_at, output int err_at, output int busy_bad);
        done_at  = -1;
        err_at   = -1;
        busy_bad = 0;
        @(negedge clk);
        src_adr = s;
        dst_adr = d;
        len     = 16'(n);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy !== 1'b1) busy_bad++;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = (c == poke_at);
            if (c == poke_at) begin
                src_adr = 32'h0000_1234;
                len     = 16'd0;
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (err === 1'b1 && err_at < 0) err_at = c;
            if (done === 1'b1 || err === 1'b1) break;
            if (busy !== 1'b1) busy_bad++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, err, wb.stb, wb.cyc, wb.we, wb.sel, wb.tga} !== 9'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl got %b exp 0", {busy, done, err, wb.stb, wb.cyc, wb.we, wb.sel, wb.tga});
        end
        vectors++;
        if (wb.adr !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_adr got %h exp 0", wb.adr);
        end
        vectors++;
        if (wb.dat_w !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_dat got %h exp 0", wb.dat_w);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_copy();
        logic [31:0] s;
        logic [31:0] d;
        int n, done_at, err_at, busy_bad, base, bbase;
        ack_mode = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                for (int i = 0; i < 8; i++) rom[i] = 8'(8'h11 * (i + 1));
                s = 32'h0;
                d = 32'h1000;
                n = 4;
            end else begin
                s = {16'($urandom), 2'b00, 14'($urandom)};
                d = {16'($urandom), 2'b10, 14'($urandom)};
                n = 1 + int'($urandom_range(0, 5));
            end
            build_expect(s, d, n);
            base  = log_q.size();
            bbase = bus_bad;
            do_copy(s, d, n, 0, done_at, err_at, busy_bad);
            vectors++;
            if (done_at !== 6 * n + 1) begin
                miscompares++;
                $display("[TB] FAIL copy%0d_latency got %0d exp %0d", k, done_at, 6 * n + 1);
            end
            vectors++;
            if (err_at !== -1 || busy_bad !== 0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL copy%0d_status got err_at=%0d busy_bad=%0d busy=%b exp -1/0/0", k, err_at, busy_bad, busy);
            end
            vectors++;
            if (log_q.size() - base !== exp_q.size()) begin
                miscompares++;
                $display("[TB] FAIL copy%0d_count got %0d exp %0d", k, log_q.size() - base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
                vectors++;
                if (log_q[base + i] !== exp_q[i]) begin
                    miscompares++;
                    $display("[TB] FAIL copy%0d_xfer%0d got %h exp %h", k, i, log_q[base + i], exp_q[i]);
                end
            end
            for (int i = 1; i < exp_q.size(); i += 2) begin
                vectors++;
                if ({ram[16'(exp_q[i].adr)], ram[16'(exp_q[i].adr + 32'd1)]} !== exp_q[i].dat) begin
                    miscompares++;
                    $display("[TB] FAIL copy%0d_ram@%h got %h exp %h", k, exp_q[i].adr,
                             {ram[16'(exp_q[i].adr)], ram[16'(exp_q[i].adr + 32'd1)]}, exp_q[i].dat);
                end
            end
            vectors++;
            if (bus_bad - bbase !== 0) begin
                miscompares++;
                $display("[TB] FAIL copy%0d_bus_rules got %0d bad cycles exp 0", k, bus_bad - bbase);
            end
        end
    endtask

    task automatic test_zero_len();
        int done_at, err_at, busy_bad, cbase;
        ack_mode = 0;
        cbase = cyc_cycles;
        do_copy($urandom, $urandom, 0, 0, done_at, err_at, busy_bad);
        vectors++;
        if (done_at !== 1) begin
            miscompares++;
            $display("[TB] FAIL zero_len_latency got %0d exp 1", done_at);
        end
        vectors++;
        if (cyc_cycles - cbase !== 0) begin
            miscompares++;
            $display("[TB] FAIL zero_len_cyc got %0d cycles exp 0", cyc_cycles - cbase);
        end
        vectors++;
        if (busy !== 1'b0 || busy_bad !== 0 || err_at !== -1) begin
            miscompares++;
            $display("[TB] FAIL zero_len_status got busy=%b busy_bad=%0d err_at=%0d exp 0/0/-1", busy, busy_bad, err_at);
        end
    endtask

    task automatic test_linger();
        logic [31:0] s;
        logic [31:0] d;
        int done_at, err_at, busy_bad, base;
        ack_mode = 1;
        s = {16'($urandom), 2'b01, 14'($urandom)};
        d = {16'($urandom), 2'b11, 14'($urandom)};
        build_expect(s, d, 4);
        base = log_q.size();
        do_copy(s, d, 4, 0, done_at, err_at, busy_bad);
        vectors++;
        if (log_q.size() - base !== 8) begin
            miscompares++;
            $display("[TB] FAIL linger_count got %0d exp 8", log_q.size() - base);
        end
        for (int i = 0; i < 8 && base + i < log_q.size(); i++) begin
            vectors++;
            if (log_q[base + i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL linger_xfer%0d got %h exp %h", i, log_q[base + i], exp_q[i]);
            end
        end
        vectors++;
        if (done_at !== 25 || err_at !== -1) begin
            miscompares++;
            $display("[TB] FAIL linger_latency got done_at=%0d err_at=%0d exp 25/-1", done_at, err_at);
        end
        ack_mode = 0;
    endtask

    task automatic test_timeout();
        int n, done_at, err_at, busy_bad, sbase, base;
        ack_mode = 2;
        n = 1 + int'($urandom_range(0, 4));
        sbase = stb_cycles;
        base  = log_q.size();
        do_copy($urandom, $urandom, n, 0, done_at, err_at, busy_bad);
        vectors++;
        if (err_at !== TMO + 1 || done_at !== -1) begin
            miscompares++;
            $display("[TB] FAIL timeout_pulse got err_at=%0d done_at=%0d exp %0d/-1", err_at, done_at, TMO + 1);
        end
        vectors++;
        if (stb_cycles - sbase !== TMO) begin
            miscompares++;
            $display("[TB] FAIL timeout_stb_len got %0d exp %0d", stb_cycles - sbase, TMO);
        end
        vectors++;
        if (busy !== 1'b0 || wb.cyc !== 1'b0 || log_q.size() !== base) begin
            miscompares++;
            $display("[TB] FAIL timeout_idle got busy=%b cyc=%b xfers=%0d exp 0/0/0", busy, wb.cyc, log_q.size() - base);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_one_shot got err=%b done=%b exp 0/0", err, done);
        end
        ack_mode = 0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        logic [31:0] d;
        int done_at, err_at, busy_bad, base, found, stray;
        ack_mode = 0;
        base  = log_q.size();
        found = 0;
        @(negedge clk);
        src_adr = {16'($urandom), 2'b00, 14'($urandom)};
        dst_adr = {16'($urandom), 2'b10, 14'($urandom)};
        len     = 16'd4;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (wb.stb === 1'b1 && wb.we === 1'b1 && log_q.size() - base == 3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (found !== 1) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_reach got %0d exp 1", found);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wb.cyc, wb.stb, wb.we, busy, done, err} !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_quiesce got %b exp 000000", {wb.cyc, wb.stb, wb.we, busy, done, err});
        end
        rst   = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_no_pulse got %0d stray cycles exp 0", stray);
        end
        s = {16'($urandom), 2'b01, 14'($urandom)};
        d = {16'($urandom), 2'b11, 14'($urandom)};
        build_expect(s, d, 2);
        base = log_q.size();
        do_copy(s, d, 2, 0, done_at, err_at, busy_bad);
        vectors++;
        if (done_at !== 13 || err_at !== -1 || busy_bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_restart got done_at=%0d err_at=%0d busy_bad=%0d exp 13/-1/0", done_at, err_at, busy_bad);
        end
        vectors++;
        if (log_q.size() - base !== 4) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_count got %0d exp 4", log_q.size() - base);
        end
        for (int i = 0; i < 4 && base + i < log_q.size(); i++) begin
            vectors++;
            if (log_q[base + i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL rst_mid_xfer%0d got %h exp %h", i, log_q[base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_busy_wrap();
        logic [31:0] d;
        int done_at, err_at, busy_bad, base;
        ack_mode = 0;
        d = {16'($urandom), 2'b10, 14'($urandom)};
        build_expect(32'hFFFF_FFFE, d, 2);
        base = log_q.size();
        do_copy(32'hFFFF_FFFE, d, 2, 1 + int'($urandom_range(0, 8)), done_at, err_at, busy_bad);
        vectors++;
        if (done_at !== 13 || err_at !== -1 || busy_bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL wrap_latency got done_at=%0d err_at=%0d busy_bad=%0d exp 13/-1/0", done_at, err_at, busy_bad);
        end
        vectors++;
        if (log_q.size() - base !== 4) begin
            miscompares++;
            $display("[TB] FAIL wrap_count got %0d exp 4", log_q.size() - base);
        end
        if (log_q.size() - base >= 3) begin
            vectors++;
            if (log_q[base + 2].adr !== 32'h0000_0000) begin
                miscompares++;
                $display("[TB] FAIL wrap_second_read_adr got %h exp 00000000", log_q[base + 2].adr);
            end
        end
        for (int i = 0; i < 4 && base + i < log_q.size(); i++) begin
            vectors++;
            if (log_q[base + i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL wrap_xfer%0d got %h exp %h", i, log_q[base + i], exp_q[i]);
            end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || wb.cyc !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_poke_ignored got busy=%b cyc=%b exp 0/0", busy, wb.cyc);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ack_mode    = 0;
        rst         = 1'b1;
        start       = 1'b0;
        src_adr     = '0;
        dst_adr     = '0;
        len         = '0;
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        test_reset();
        test_copy();
        test_zero_len();
        test_linger();
        test_timeout();
        test_reset_mid();
        test_busy_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
